// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   StateWidth : width of the FSM state register
//   state_e    : FSM states (idle -> run -> done -> idle)
package serial_subtractor_pkg;

  localparam int unsigned StateWidth = 2;

  typedef enum logic [StateWidth-1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   a, b : addend bits
//   cin  : carry in
//   sum  : a ^ b ^ cin
//   cout : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock, computed on a
// single full-adder cell as a + ~b + ~bin.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready only while idle)
//   a, b, bin            : minuend, subtrahend, borrow-in
//   out_valid / out_ready: result handshake
//   diff, bout, ovf      : difference, borrow-out, signed overflow (held after handshake)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic fa_sum;
  logic fa_cout;

  // Subtraction as a + ~b + carry, where carry starts at ~bin.
  full_adder u_full_adder (
    .a    (a_sr_q[0]),
    .b    (~b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    carry_d   = carry_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    ovf_d     = ovf_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = ~bin;
          cnt_d   = '0;
          // Operand signs are kept because the shift registers lose them during the run.
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = StRun;
        end
      end
      StRun: begin
        a_sr_d               = a_sr_q >> 1;
        b_sr_d               = b_sr_q >> 1;
        diff_sr_d            = diff_sr_q >> 1;
        diff_sr_d[WIDTH-1]   = fa_sum;
        carry_d              = fa_cout;
        cnt_d                = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          state_d = StDone;
          diff_d  = diff_sr_d;
          // A final carry of 1 means no borrow was needed.
          bout_d  = ~fa_cout;
          ovf_d   = (a_msb_q != b_msb_q) && (fa_sum != a_msb_q);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      carry_q   <= 1'b0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      carry_q   <= carry_d;
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    diff      = diff_q;
    bout      = bout_q;
    ovf       = ovf_q;
  end

endmodule
